// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit saturating direction counters and a combinational mispredict check.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              lookup_en,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_npc,
  input  logic              upd_valid,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [WORD_W-1:0] upd_pred_npc,
  output logic              mispredict,
`ifdef BPU_STATS_EN
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_mispredicts,
`endif
  output logic [WORD_W-1:0] correct_npc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [WORD_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[WORD_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[WORD_W-1:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && ctr_q[lk_idx][1];
  assign pred_npc   = pred_taken ? target_q[lk_idx] : lookup_pc + WORD_W'(4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_npc)));
  assign correct_npc = upd_taken ? upd_target : upd_pc + WORD_W'(4);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_q[up_idx]    <= (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          target_q[up_idx] <= upd_target;
        end else begin
          ctr_q[up_idx] <= (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Taken miss replaces whatever occupies the slot, starting weakly taken.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_en && (stat_lookups != 32'hFFFF_FFFF)) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^lookup_pc[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], lookup_en};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit (ENTRIES=16, WORD_W=32).
// Stats checks are compiled in only when BPU_STATS_EN is defined.
module tb_branch_predict_unit;

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_npc;
  logic        mispredict;
  logic [31:0] correct_npc;
`ifdef BPU_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
`endif

  branch_predict_unit #(.ENTRIES(16), .WORD_W(32)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .flush          (flush),
    .lookup_en      (lookup_en),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .pred_npc       (pred_npc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_npc   (upd_pred_npc),
    .mispredict     (mispredict),
`ifdef BPU_STATS_EN
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts),
`endif
    .correct_npc    (correct_npc)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        flush;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] upnpc;
    logic [31:0] lpc;
    logic        e_pt;
    logic [31:0] e_npc;
    logic        e_mis;
    logic [31:0] e_cnpc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected value queued (actual %h)", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: actual %h required %h", name, act, exp);
      end
    end
  endtask

  task automatic av(input logic f, input logic uv, input logic [31:0] upc, input logic ut,
                    input logic [31:0] utgt, input logic upt, input logic [31:0] upnpc,
                    input logic [31:0] lpc, input logic ept, input logic [31:0] enpc,
                    input logic emis, input logic [31:0] ecnpc);
    vec_t v;
    v.flush = f; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
    v.upnpc = upnpc; v.lpc = lpc; v.e_pt = ept; v.e_npc = enpc; v.e_mis = emis;
    v.e_cnpc = ecnpc;
    vecs.push_back(v);
  endtask

  // Driver: inputs change after the falling edge, outputs sampled before the rising edge.
  task automatic drive_idle();
    flush = 1'b0; lookup_en = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_npc = '0;
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    @(negedge CLK);
    flush = v.flush; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
    upd_target = v.utgt; upd_pred_taken = v.upt; upd_pred_npc = v.upnpc;
    lookup_pc = v.lpc;
    exp_q.push_back({31'd0, v.e_pt});
    exp_q.push_back(v.e_npc);
    exp_q.push_back({31'd0, v.e_mis});
    exp_q.push_back(v.e_cnpc);
    #2;
    check($sformatf("v%0d pred_taken", n), {31'd0, pred_taken});
    check($sformatf("v%0d pred_npc", n), pred_npc);
    check($sformatf("v%0d mispredict", n), {31'd0, mispredict});
    check($sformatf("v%0d correct_npc", n), correct_npc);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic lookup_check(input string name, input logic [31:0] pc,
                              input logic ept, input logic [31:0] enpc);
    @(negedge CLK);
    drive_idle();
    lookup_pc = pc;
    exp_q.push_back({31'd0, ept});
    exp_q.push_back(enpc);
    #2;
    check({name, " pred_taken"}, {31'd0, pred_taken});
    check({name, " pred_npc"}, pred_npc);
  endtask

  initial begin
    nRST = 1'b0;
    drive_idle();
    do_reset();

    //  f uv upc          ut utgt         upt upnpc       lpc           pt npc          mis cnpc
    av(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,     32'h100,      0, 32'h104,      0, 32'h4);
    av(0, 1, 32'h100,    1, 32'h200,    0, 32'h104,   32'h100,      0, 32'h104,      1, 32'h200);
    av(0, 1, 32'h100,    0, 32'h0,      1, 32'h200,   32'h100,      1, 32'h200,      1, 32'h104);
    av(0, 1, 32'h100,    0, 32'h0,      0, 32'h104,   32'h100,      0, 32'h104,      0, 32'h104);
    av(0, 1, 32'h100,    0, 32'h0,      0, 32'h104,   32'h100,      0, 32'h104,      0, 32'h104);
    av(0, 1, 32'h100,    1, 32'h300,    0, 32'h104,   32'h100,      0, 32'h104,      1, 32'h300);
    av(0, 1, 32'h100,    1, 32'h300,    0, 32'h104,   32'h100,      0, 32'h104,      1, 32'h300);
    av(0, 1, 32'h100,    1, 32'h300,    1, 32'h300,   32'h100,      1, 32'h300,      0, 32'h300);
    av(0, 1, 32'h100,    1, 32'h300,    1, 32'h2FC,   32'h100,      1, 32'h300,      1, 32'h300);
    av(0, 1, 32'h100,    0, 32'h0,      1, 32'h300,   32'h100,      1, 32'h300,      1, 32'h104);
    av(0, 1, 32'h140,    1, 32'h500,    0, 32'h144,   32'h100,      1, 32'h300,      1, 32'h500);
    av(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,     32'h100,      0, 32'h104,      0, 32'h4);
    av(0, 1, 32'h180,    0, 32'h0,      0, 32'h184,   32'h140,      1, 32'h500,      0, 32'h184);
    av(0, 0, 32'h180,    1, 32'h700,    0, 32'h184,   32'h140,      1, 32'h500,      0, 32'h700);
    av(1, 1, 32'h244,    1, 32'h600,    0, 32'h248,   32'h140,      1, 32'h500,      1, 32'h600);
    av(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,     32'h140,      0, 32'h144,      0, 32'h4);
    av(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,     32'h244,      0, 32'h248,      0, 32'h4);
    av(0, 1, 32'h244,    1, 32'h600,    0, 32'h248,   32'h245,      0, 32'h249,      1, 32'h600);
    av(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,     32'h246,      1, 32'h600,      0, 32'h4);
    av(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,     32'hFFFFFFFC, 0, 32'h0,        0, 32'h4);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Reset beats a simultaneous taken update and wipes the live 0x244 entry.
    @(negedge CLK);
    drive_idle();
    nRST = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h800;
    @(negedge CLK);
    drive_idle();
    nRST = 1'b1;
    lookup_check("rst_vs_upd", 32'h300, 1'b0, 32'h304);
    lookup_check("rst_clears", 32'h244, 1'b0, 32'h248);

    // Fresh allocation after reset must predict taken immediately (counter 10).
    @(negedge CLK);
    drive_idle();
    upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_target = 32'h2000;
    lookup_check("alloc_after_rst", 32'h1000, 1'b1, 32'h2000);

`ifdef BPU_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      drive_idle();
      lookup_en = 1'b1;
      lookup_pc = 32'h400 + 32'(i * 4);
      if (i < 2) begin
        upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h600;
      end
    end
    @(negedge CLK);
    drive_idle();
    flush = 1'b1;
    @(negedge CLK);
    drive_idle();
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd2);
    check("stat_lookups", stat_lookups);
    check("stat_mispredicts", stat_mispredicts);
`endif

    @(negedge CLK);
    drive_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
